sr_lock_arbiter: RTL
====================

# sr_lock_arbiter

Round-robin lock controller that shares one set/reset ownership flag among N requesters. Each requester raises a request; the arbiter sets the flag for exactly one winner, holds it until the winner releases, drops its request or exceeds a hold limit, then resets the flag. It sits in front of any shared resource guarded by an SR-style busy bit and owns all set/reset sequencing of that bit.

## Interface
- N, 4, number of requesters (N >= 2)
- HOLD_MAX, 255, maximum cycles a grant may be held; 0 disables the timeout
- CW, 8, hold counter width; HOLD_MAX must fit in CW bits
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N  per-requester request, level, held until granted or abandoned
- rel  input  N  per-requester release strobe; only the bit of the current owner is honoured
- gnt  output  N  one-hot grant, registered; all zero when not busy
- busy  output  1  ownership flag (SR semantics: set on grant, reset on release)
- owner  output  clog2(N)  index of current owner; 0 when not busy
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- Reset (rst_n low, asynchronous): state IDLE, gnt=0, busy=0, owner=0, timeout=0, hold_cnt=0, rr pointer=0. All outputs take these values immediately, without waiting for a clock edge.
- States: IDLE, OWNED, GAP.
- IDLE: on a clock edge with req != 0, the arbiter picks the first set req bit searching upward from the rr pointer, wrapping from N-1 to 0. Then: state becomes OWNED, gnt[winner]=1, busy=1, owner=winner, hold_cnt=0. With req == 0 the arbiter stays in IDLE.
- OWNED: hold_cnt increments each cycle and saturates at its maximum. The grant ends at an edge where any of the following holds:
  - rel[owner]=1
  - req[owner]=0
  - HOLD_MAX != 0 and hold_cnt == HOLD_MAX-1
- On grant end: state becomes GAP, gnt=0, busy=0, owner=0, rr pointer = (owner+1) mod N. If the cause was only the hold limit (rel and req conditions both false), timeout=1 for one cycle.
- GAP: lasts one cycle, then the arbiter returns to IDLE unconditionally. timeout clears.
- The reset condition dominates the set condition. Within OWNED, no new grant is evaluated, and changes on non-owner req bits are ignored.
- rel bits of non-owners are ignored in every state. rel in IDLE or GAP has no effect.
- At most one gnt bit is high in any cycle, and busy == |gnt always.

## Timing
- Grant latency: req sampled at edge k while IDLE -> gnt high after edge k. A req asserted during OWNED or GAP waits for the return to IDLE.
- Release latency: rel[owner] sampled at edge k -> gnt/busy low after edge k.
- Re-arbitration: gnt is low for at least 2 cycles between grants. The sequence is GAP at edge k+1 to IDLE, then the next grant at edge k+2 at the earliest.
- Timeout: with HOLD_MAX=M, gnt stays high for exactly M cycles when never released. timeout is high during the first GAP cycle.
- A requester that is revoked but keeps req high is re-granted only after every other pending requester in round-robin order. If it is alone, it is re-granted after the GAP.
- Reset during OWNED: gnt and busy drop asynchronously, no timeout pulse is produced, and the rr pointer returns to 0.

## Test plan
- Reset then single requester: req=4'b0010 -> gnt=4'b0010, owner=1, busy=1 one cycle later. rel[1] pulse -> gnt=0 next edge; gnt low for 2 cycles.
- Round robin: req=4'b1111 held, each owner releases after 3 cycles -> grant order 0,1,2,3,0 with a 2-cycle gap between grants.
- Timeout: HOLD_MAX=5, req=4'b0100 held and no rel -> gnt[2] high exactly 5 cycles, timeout pulses once, re-grant to 2 after the gap.
- Foreign release and owner drop: owner 0 with rel=4'b0010 -> no effect. Then req[0] falls -> release at the next edge, timeout stays 0.
- Simultaneous hold limit and rel[owner] on the same edge -> release with timeout=0. The next grant searches from owner+1.
- Async reset mid-grant: rst_n low between edges while gnt=4'b1000 -> all outputs 0 immediately. After reset release with req=4'b1001 -> grant goes to 0.

Source files
------------

// File: rtl/sr_lock_arbiter_if.sv
// Request/grant bundle between N requesters and the lock arbiter.
interface sr_lock_arbiter_if #(
  parameter int N = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  rel;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [OW-1:0] owner;
  logic          timeout;

  // Requester side drives req/rel and observes the lock state.
  modport master (
    output req,
    output rel,
    input  gnt,
    input  busy,
    input  owner,
    input  timeout
  );

  // Arbiter side samples req/rel and owns the lock state.
  modport slave (
    input  req,
    input  rel,
    output gnt,
    output busy,
    output owner,
    output timeout
  );
endinterface

// File: rtl/sr_lock_arbiter.sv
// Round-robin owner of a single SR-style busy flag shared by N requesters.
// A grant sets the flag; release, request drop or the hold limit resets it,
// followed by a one-cycle gap before the next arbitration.
module sr_lock_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 255,
  parameter int CW       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_lock_arbiter_if.slave    bus
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam bit HOLD_EN = (HOLD_MAX != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [OW-1:0] owner;
  logic          timeout;
  logic [CW-1:0] hold_cnt;
  logic [OW-1:0] rr;

  logic [OW-1:0] pick;
  logic          found;
  logic [OW-1:0] cand;
  logic          end_rel;
  logic          end_req;
  logic          end_hold;

  // Next index with wrap from N-1 back to 0.
  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
    if (v == OW'(N - 1)) return '0;
    else                 return v + 1'b1;
  endfunction

  // Round-robin search: first set req bit at or above rr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = rr;
    for (int i = 0; i < N; i++) begin
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  // Grant-end causes; only the owner's bits matter.
  assign end_rel  = bus.rel[owner];
  assign end_req  = !bus.req[owner];
  assign end_hold = HOLD_EN && (hold_cnt == HOLD_LAST);

  // Lock FSM: grant, hold, revoke, one-cycle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      owner    <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      rr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (found) begin
            state       <= OWNED;
            gnt         <= '0;
            gnt[pick]   <= 1'b1;
            busy        <= 1'b1;
            owner       <= pick;
            hold_cnt    <= '0;
          end
        end
        OWNED: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
          if (end_rel || end_req || end_hold) begin
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            owner   <= '0;
            rr      <= wrap_inc(owner);
            // Pulse only when the hold limit alone ended the grant.
            timeout <= end_hold && !end_rel && !end_req;
          end
        end
        GAP: begin
          state   <= IDLE;
          timeout <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          owner   <= '0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.busy    = busy;
  assign bus.owner   = owner;
  assign bus.timeout = timeout;

endmodule
